// File: rtl/snn_input_loader_if.sv
// Bundle between the input loader and its neighbours: UART byte handshake,
// input-image RAM write port and the snn_core start/done handshake.
interface snn_input_loader_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  rx_rdy;
    logic [7:0]            rx_data;
    logic                  clr_rx_rdy;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_data;
    logic                  ram_we;
    logic                  load_active;
    logic                  snn_start;
    logic                  snn_done;
    logic                  frame_err;

    modport master (
        output rx_rdy, rx_data, snn_done,
        input  clr_rx_rdy, ram_addr, ram_data, ram_we, load_active, snn_start, frame_err
    );

    modport slave (
        input  rx_rdy, rx_data, snn_done,
        output clr_rx_rdy, ram_addr, ram_data, ram_we, load_active, snn_start, frame_err
    );
endinterface

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes LSB-first into the 1-bit input-image RAM and starts snn_core.
// Optional inter-byte frame timeout is built when SNN_LOADER_TIMEOUT_EN is defined.
module snn_input_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int ADDR_WIDTH     = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic               clk,
    input logic               rst_n,
    snn_input_loader_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        START,
        WAIT_CORE
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    if ((NUM_PIXELS % 8) != 0 || NUM_PIXELS < 8 || NUM_PIXELS > (1 << ADDR_WIDTH) ||
        TIMEOUT_CYCLES < 1) begin : g_bad_config
        $error("snn_input_loader: unsupported NUM_PIXELS/ADDR_WIDTH/TIMEOUT_CYCLES");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic [7:0]            byte_q, byte_d;
    logic [2:0]            bit_q, bit_d;
    logic                  timeout_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            byte_q     <= '0;
            bit_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            byte_q     <= byte_d;
            bit_q      <= bit_d;
        end
    end

    // snn_done is only looked at in WAIT_CORE, so a stale done during START is dropped
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        case (state_q)
            IDLE: begin
                if (bus.rx_rdy) begin
                    byte_d  = bus.rx_data;
                    bit_d   = 3'd0;
                    state_d = UNPACK;
                end else if (timeout_hit) begin
                    addr_cnt_d = '0;
                end
            end
            UNPACK: begin
                addr_cnt_d = addr_cnt_q + ADDR_ONE;
                bit_d      = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = (addr_cnt_q == LAST_ADDR) ? START : IDLE;
                end
            end
            START: begin
                addr_cnt_d = '0;
                state_d    = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (bus.snn_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.clr_rx_rdy  = 1'b0;
        bus.ram_we      = 1'b0;
        bus.load_active = 1'b0;
        bus.snn_start   = 1'b0;
        case (state_q)
            IDLE: begin
                bus.load_active = (addr_cnt_q != '0);
            end
            UNPACK: begin
                bus.ram_we      = 1'b1;
                bus.load_active = 1'b1;
                bus.clr_rx_rdy  = (bit_q == 3'd0);
            end
            START: begin
                bus.snn_start = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ram_addr = addr_cnt_q;
    assign bus.ram_data = byte_q[bit_q];

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             frame_err_q;
    logic             idle_partial;

    // Idle time only counts while a partial frame is waiting for its next byte
    always_comb begin
        idle_partial = (state_q == IDLE) && (addr_cnt_q != '0) && !bus.rx_rdy;
        timeout_hit  = idle_partial && (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
        timer_d      = (idle_partial && !timeout_hit) ? timer_q + TMR_W'(1) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            frame_err_q <= timeout_hit;
        end
    end

    assign bus.frame_err = frame_err_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

endmodule
